// File: rtl/scm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scm_pkg
// Brief    : Shared types and constants for the 1W-32b / 1R-64b SCM wrapper.
// Revision : 1.0
// ============================================================================
package scm_pkg;

  // Write-merge controller states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PAIR     = 2'd1,
    MERGE_RD = 2'd2,
    MERGE_WR = 2'd3
  } scm_state_e;

  // Half-select encoding carried in write address bit 0
  localparam logic LO_HALF = 1'b0;
  localparam logic HI_HALF = 1'b1;

endpackage
`default_nettype wire

// File: rtl/register_file_1r_1w.sv
`default_nettype none
// ============================================================================
// Module   : register_file_1r_1w
// Brief    : Full-width storage cut: one registered read port, one write port,
//            write takes effect at the clock edge. Contents are not reset.
// Revision : 1.0
// ============================================================================
module register_file_1r_1w #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  ReadEnable,
  input  logic [ADDR_WIDTH-1:0] ReadAddr,
  output logic [DATA_WIDTH-1:0] ReadData,
  input  logic                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0] WriteAddr,
  input  logic [DATA_WIDTH-1:0] WriteData
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  // Row write and registered read; a same-edge read returns the old contents
  always_ff @(posedge clk) begin
    if (WriteEnable) r_mem[WriteAddr] <= WriteData;
    if (ReadEnable)  ReadData         <= r_mem[ReadAddr];
  end

endmodule
`default_nettype wire

// File: rtl/scm_1w_32b_1r_64b.sv
`default_nettype none
// ============================================================================
// Module   : scm_1w_32b_1r_64b
// Brief    : 32-bit write / 64-bit read memory built on a full-row storage cut.
//            Half-row writes are paired or merged (read-modify-write) through
//            a staging register plus a one-entry hold register; reads are
//            kept coherent by overlaying pending halves on the cut data.
// Revision : 1.0
// ============================================================================
module scm_1w_32b_1r_64b
  import scm_pkg::*;
#(
  parameter int WADDR_WIDTH = 6,
  parameter int RADDR_WIDTH = WADDR_WIDTH - 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   WriteEnable,
  input  logic [WADDR_WIDTH-1:0] WriteAddr,
  input  logic [31:0]            WriteData,
  output logic                   WriteReady,
  input  logic                   ReadEnable,
  input  logic [RADDR_WIDTH-1:0] ReadAddr,
  output logic                   ReadGnt,
  output logic [63:0]            ReadData,
  output logic                   ReadValid,
  output logic                   Idle
);

  scm_state_e r_state, w_state_nxt;

  logic                   r_stg_valid, r_stg_half;
  logic [RADDR_WIDTH-1:0] r_stg_row;
  logic [31:0]            r_stg_data;
  logic                   r_hld_valid, r_hld_half;
  logic [RADDR_WIDTH-1:0] r_hld_row;
  logic [31:0]            r_hld_data;

  logic                   w_wr_acc, w_rd_gnt, w_wr_half;
  logic [RADDR_WIDTH-1:0] w_wr_row;
  logic                   w_stg_ld_wr, w_stg_ld_hld, w_stg_clr, w_hld_ld, w_hld_clr;
  logic                   w_cut_we, w_cut_re;
  logic [RADDR_WIDTH-1:0] w_cut_raddr;
  logic [63:0]            w_cut_wdata, w_cut_rdata;

  logic [1:0]             w_ov_hit, r_ov_hit;
  logic [1:0][31:0]       w_ov_data, r_ov_data;

  assign WriteReady = (r_state == IDLE) || (r_state == PAIR);
  assign ReadGnt    = (r_state != MERGE_RD);
  assign Idle       = (r_state == IDLE) && !r_stg_valid && !r_hld_valid;
  assign w_wr_acc   = WriteEnable && WriteReady;
  assign w_rd_gnt   = ReadEnable && ReadGnt;
  assign w_wr_row   = WriteAddr[WADDR_WIDTH-1:1];
  assign w_wr_half  = WriteAddr[0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, staging/hold control and storage-cut port steering
  always_comb begin
    w_state_nxt  = r_state;
    w_stg_ld_wr  = 1'b0;
    w_stg_ld_hld = 1'b0;
    w_stg_clr    = 1'b0;
    w_hld_ld     = 1'b0;
    w_hld_clr    = 1'b0;
    w_cut_we     = 1'b0;
    w_cut_wdata  = '0;
    w_cut_re     = ReadEnable;
    w_cut_raddr  = ReadAddr;
    case (r_state)
      IDLE: begin
        if (w_wr_acc) begin
          w_stg_ld_wr = 1'b1;
          w_state_nxt = PAIR;
        end
      end
      PAIR: begin
        if (w_wr_acc && (w_wr_row == r_stg_row)) begin
          if (w_wr_half != r_stg_half) begin
            // Partner half arrived: the full row goes straight to the cut
            w_cut_we    = 1'b1;
            w_cut_wdata = (r_stg_half == LO_HALF) ? {WriteData, r_stg_data}
                                                  : {r_stg_data, WriteData};
            w_stg_clr   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_stg_ld_wr = 1'b1;
          end
        end else if (w_wr_acc) begin
          w_hld_ld    = 1'b1;
          w_state_nxt = MERGE_RD;
        end else begin
          w_state_nxt = MERGE_RD;
        end
      end
      MERGE_RD: begin
        // Cut read port is borrowed for the staged row
        w_cut_re    = 1'b1;
        w_cut_raddr = r_stg_row;
        w_state_nxt = MERGE_WR;
      end
      MERGE_WR: begin
        w_cut_we    = 1'b1;
        w_cut_wdata = (r_stg_half == LO_HALF) ? {w_cut_rdata[63:32], r_stg_data}
                                              : {r_stg_data, w_cut_rdata[31:0]};
        if (r_hld_valid) begin
          w_stg_ld_hld = 1'b1;
          w_hld_clr    = 1'b1;
          w_state_nxt  = PAIR;
        end else begin
          w_stg_clr    = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Staging and hold registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_valid <= 1'b0;
      r_stg_half  <= LO_HALF;
      r_stg_row   <= '0;
      r_stg_data  <= '0;
      r_hld_valid <= 1'b0;
      r_hld_half  <= LO_HALF;
      r_hld_row   <= '0;
      r_hld_data  <= '0;
    end else begin
      if (w_stg_ld_wr) begin
        r_stg_valid <= 1'b1;
        r_stg_row   <= w_wr_row;
        r_stg_half  <= w_wr_half;
        r_stg_data  <= WriteData;
      end else if (w_stg_ld_hld) begin
        r_stg_valid <= 1'b1;
        r_stg_row   <= r_hld_row;
        r_stg_half  <= r_hld_half;
        r_stg_data  <= r_hld_data;
      end else if (w_stg_clr) begin
        r_stg_valid <= 1'b0;
      end
      if (w_hld_ld) begin
        r_hld_valid <= 1'b1;
        r_hld_row   <= w_wr_row;
        r_hld_half  <= w_wr_half;
        r_hld_data  <= WriteData;
      end else if (w_hld_clr) begin
        r_hld_valid <= 1'b0;
      end
    end
  end

  // Per-half freshest pending value for the read row; later sources win
  always_comb begin
    w_ov_hit  = '0;
    w_ov_data = '0;
    for (int h = 0; h < 2; h++) begin
      if (r_stg_valid && (r_stg_row == ReadAddr) && (r_stg_half == h[0])) begin
        w_ov_hit[h]  = 1'b1;
        w_ov_data[h] = r_stg_data;
      end
      if (r_hld_valid && (r_hld_row == ReadAddr) && (r_hld_half == h[0])) begin
        w_ov_hit[h]  = 1'b1;
        w_ov_data[h] = r_hld_data;
      end
      if (w_wr_acc && (w_wr_row == ReadAddr) && (w_wr_half == h[0])) begin
        w_ov_hit[h]  = 1'b1;
        w_ov_data[h] = WriteData;
      end
    end
  end

  // Capture the overlay decision at grant time and flag the response cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ReadValid <= 1'b0;
      r_ov_hit  <= '0;
      r_ov_data <= '0;
    end else begin
      ReadValid <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_ov_hit  <= w_ov_hit;
        r_ov_data <= w_ov_data;
      end
    end
  end

  assign ReadData = {r_ov_hit[1] ? r_ov_data[1] : w_cut_rdata[63:32],
                     r_ov_hit[0] ? r_ov_data[0] : w_cut_rdata[31:0]};

  register_file_1r_1w #(
    .ADDR_WIDTH (RADDR_WIDTH),
    .DATA_WIDTH (64)
  ) u_cut (
    .clk         (clk),
    .ReadEnable  (w_cut_re),
    .ReadAddr    (w_cut_raddr),
    .ReadData    (w_cut_rdata),
    .WriteEnable (w_cut_we),
    .WriteAddr   (r_stg_row),
    .WriteData   (w_cut_wdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_scm_1w_32b_1r_64b.sv
`default_nettype none
// ============================================================================
// Module   : tb_scm_1w_32b_1r_64b
// Brief    : Self-checking bench: directed vector table, reset-in-merge
//            sequence and a random phase, with a read-data scoreboard fed by
//            a plain 64-bit memory model.
// Revision : 1.0
// ============================================================================
module tb_scm_1w_32b_1r_64b;

  logic        clk, rst_n;
  logic        WriteEnable, WriteReady, ReadEnable, ReadGnt, ReadValid, Idle;
  logic [5:0]  WriteAddr;
  logic [31:0] WriteData;
  logic [4:0]  ReadAddr;
  logic [63:0] ReadData;

  scm_1w_32b_1r_64b dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .WriteEnable (WriteEnable),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData),
    .WriteReady  (WriteReady),
    .ReadEnable  (ReadEnable),
    .ReadAddr    (ReadAddr),
    .ReadGnt     (ReadGnt),
    .ReadData    (ReadData),
    .ReadValid   (ReadValid),
    .Idle        (Idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic        re;
    logic [4:0]  raddr;
    logic        x_wrdy;
    logic        x_gnt;
    logic        x_idle;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  mask;
  } rd_t;

  vec_t        vt[$];
  rd_t         exp_q[$];
  logic [63:0] m_mem [32];
  logic [1:0]  m_wr  [32];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] m64(input logic [1:0] m);
    return {{32{m[1]}}, {32{m[0]}}};
  endfunction

  task automatic model_write(input logic [5:0] a, input logic [31:0] d);
    if (a[0]) m_mem[a[5:1]][63:32] = d;
    else      m_mem[a[5:1]][31:0]  = d;
    m_wr[a[5:1]][a[0]] = 1'b1;
  endtask

  task automatic push_read(input logic [4:0] r);
    rd_t e;
    e.data = m_mem[r];
    e.mask = m_wr[r];
    exp_q.push_back(e);
  endtask

  // Advance one clock, then check the read response channel
  task automatic tick();
    rd_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rvalid", {63'd0, ReadValid}, 64'd1);
      check("rdata", ReadData & m64(e.mask), e.data & m64(e.mask));
    end else begin
      check("rvalid_idle", {63'd0, ReadValid}, 64'd0);
    end
  endtask

  task automatic add(input logic we, input logic [5:0] wa, input logic [31:0] wd,
                     input logic re, input logic [4:0] ra,
                     input logic xw, input logic xg, input logic xi);
    vec_t v;
    v.we = we; v.waddr = wa; v.wdata = wd; v.re = re; v.raddr = ra;
    v.x_wrdy = xw; v.x_gnt = xg; v.x_idle = xi;
    vt.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    WriteEnable = v.we; WriteAddr = v.waddr; WriteData = v.wdata;
    ReadEnable  = v.re; ReadAddr  = v.raddr;
    #1;
    check("wready", {63'd0, WriteReady}, {63'd0, v.x_wrdy});
    check("rgnt",   {63'd0, ReadGnt},    {63'd0, v.x_gnt});
    check("idle",   {63'd0, Idle},       {63'd0, v.x_idle});
    if (v.we && v.x_wrdy) model_write(v.waddr, v.wdata);
    if (v.re && v.x_gnt)  push_read(v.raddr);
    tick();
  endtask

  task automatic clear_inputs();
    WriteEnable = 1'b0; WriteAddr = '0; WriteData = '0;
    ReadEnable  = 1'b0; ReadAddr  = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0;
      m_wr[i]  = 2'b00;
    end

    //  we wa  wdata         re ra  wrdy gnt idle
    // Pair lo/hi of row 2, then read it back
    add(1, 4,  32'h11111111, 0, 0,  1, 1, 1);
    add(1, 5,  32'h22222222, 0, 0,  1, 1, 0);
    add(0, 0,  32'h0,        1, 2,  1, 1, 1);
    add(0, 0,  32'h0,        0, 0,  1, 1, 1);
    // Row 3 full, then lone hi write merged through MERGE_RD/MERGE_WR
    add(1, 6,  32'hBBBBBBBB, 0, 0,  1, 1, 1);
    add(1, 7,  32'hAAAAAAAA, 0, 0,  1, 1, 0);
    add(1, 7,  32'hCCCCCCCC, 0, 0,  1, 1, 1);
    add(0, 0,  32'h0,        0, 0,  1, 1, 0);
    add(0, 0,  32'h0,        0, 0,  0, 0, 0);
    add(0, 0,  32'h0,        0, 0,  0, 1, 0);
    add(0, 0,  32'h0,        1, 3,  1, 1, 1);
    // Different-row write loads HLD; HLD row read during MERGE_WR
    add(1, 0,  32'h00000001, 0, 0,  1, 1, 1);
    add(1, 2,  32'h00000002, 0, 0,  1, 1, 0);
    add(0, 0,  32'h0,        1, 0,  0, 0, 0);
    add(0, 0,  32'h0,        1, 1,  0, 1, 0);
    add(0, 0,  32'h0,        0, 0,  1, 1, 0);
    add(0, 0,  32'h0,        0, 0,  0, 0, 0);
    add(0, 0,  32'h0,        0, 0,  0, 1, 0);
    add(0, 0,  32'h0,        1, 0,  1, 1, 1);
    add(0, 0,  32'h0,        1, 1,  1, 1, 1);
    // Same-cycle forward, then read held off in MERGE_RD, granted in MERGE_WR
    add(1, 12, 32'h00000005, 1, 6,  1, 1, 1);
    add(0, 0,  32'h0,        0, 0,  1, 1, 0);
    add(0, 0,  32'h0,        1, 6,  0, 0, 0);
    add(0, 0,  32'h0,        1, 6,  0, 1, 0);
    add(0, 0,  32'h0,        1, 6,  1, 1, 1);
    // Back-to-back pairs, one write per cycle, read during completing pair
    add(1, 16, 32'hD0D0D0D1, 0, 0,  1, 1, 1);
    add(1, 17, 32'hD0D0D0D2, 0, 0,  1, 1, 0);
    add(1, 18, 32'hD0D0D0D3, 0, 0,  1, 1, 1);
    add(1, 19, 32'hD0D0D0D4, 1, 9,  1, 1, 0);
    add(0, 0,  32'h0,        1, 8,  1, 1, 1);
    add(0, 0,  32'h0,        1, 9,  1, 1, 1);
    add(0, 0,  32'h0,        0, 0,  1, 1, 1);

    // Reset state
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wready", {63'd0, WriteReady}, 64'd1);
    check("rst_rgnt",   {63'd0, ReadGnt},    64'd1);
    check("rst_rvalid", {63'd0, ReadValid},  64'd0);
    check("rst_idle",   {63'd0, Idle},       64'd1);
    rst_n = 1'b1;
    tick();

    foreach (vt[i]) apply(vt[i]);
    clear_inputs();

    // Reset asserted while in MERGE_WR drops the merge
    WriteEnable = 1'b1; WriteAddr = 6'd20; WriteData = 32'h00000077;
    tick();
    clear_inputs();
    tick();
    tick();
    check("mwr_wready", {63'd0, WriteReady}, 64'd0);
    check("mwr_rgnt",   {63'd0, ReadGnt},    64'd1);
    rst_n = 1'b0;
    #1;
    check("rstm_wready", {63'd0, WriteReady}, 64'd1);
    check("rstm_rgnt",   {63'd0, ReadGnt},    64'd1);
    check("rstm_rvalid", {63'd0, ReadValid},  64'd0);
    check("rstm_idle",   {63'd0, Idle},       64'd1);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_idle", {63'd0, Idle}, 64'd1);
    tick();
    check("post_rst_idle2",   {63'd0, Idle},       64'd1);
    check("post_rst_wready2", {63'd0, WriteReady}, 64'd1);

    // Random traffic over a few rows; handshakes decide acceptance
    for (int c = 0; c < 400; c++) begin
      WriteEnable = ($urandom_range(0, 3) != 0);
      WriteAddr   = 6'($urandom_range(0, 15));
      WriteData   = $urandom;
      ReadEnable  = ($urandom_range(0, 1) != 0);
      ReadAddr    = 5'($urandom_range(0, 7));
      #1;
      if (WriteEnable && WriteReady) model_write(WriteAddr, WriteData);
      if (ReadEnable && ReadGnt)     push_read(ReadAddr);
      tick();
    end
    clear_inputs();

    // Drain pending merges, bounded
    begin
      int budget;
      budget = 0;
      while (!Idle && budget < 20) begin
        tick();
        budget++;
      end
      check("drain_idle", {63'd0, Idle}, 64'd1);
    end

    // Read back every exercised row after draining
    for (int r = 0; r < 10; r++) begin
      ReadEnable = 1'b1;
      ReadAddr   = 5'(r);
      #1;
      check("final_rgnt", {63'd0, ReadGnt}, 64'd1);
      push_read(5'(r));
      tick();
    end
    clear_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
